exec_sequencer: RTL and testbench

//  Execution controller for the single-cycle RISC-V core. Issues a one-cycle clock-enable
//  (cpu_en) to ProgramCounter, RegisterFile, Datamemory and ParallelOUT, all on clk.

---
 rtl/core_pkg.sv | 13 +
 rtl/exec_sequencer_if.sv | 26 ++
 rtl/exec_sequencer_step_debouncer.sv | 45 ++++
 rtl/exec_sequencer.sv | 122 ++++++++++++
 tb/tb_exec_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the execution sequencer: FSM state encoding and the
// EBREAK opcode that halts free-running execution.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } seq_state_t;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the execution sequencer and the surrounding core.
interface exec_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run_sw;
    logic             step_key;
    logic             bp_en;
    logic [7:0]       bp_addr;
    logic [7:0]       pc;
    logic [31:0]      inst;
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        output run_sw, step_key, bp_en, bp_addr, pc, inst,
        input  cpu_en, state, halted, retired
    );

    modport slave (
        input  run_sw, step_key, bp_en, bp_addr, pc, inst,
        output cpu_en, state, halted, retired
    );

endinterface

// File: rtl/exec_sequencer_step_debouncer.sv
// Synchronises the raw active-low step key, filters bounce with a down-counter,
// and emits a one-cycle pulse on each accepted press (debounced 1->0).
module step_debouncer #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);

    localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] LOAD = DW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [DW-1:0] cnt;

    // cnt reloads whenever the sample matches the accepted level, so only an
    // unbroken run of DB_CYCLES differing samples reaches terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= LOAD;
            pulse <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= LOAD;
            end else if (cnt == '0) begin
                level <= sync2;
                cnt   <= LOAD;
                pulse <= ~sync2;
            end else begin
                cnt <= cnt - DW'(1);
            end
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execution controller: issues one-cycle cpu_en from a RUN prescaler or a
// debounced step key, halting on PC breakpoint or EBREAK with step-over.
//
// state   | meaning
// IDLE    | stopped; each accepted step press issues one cpu_en
// RUN     | free-run; cpu_en every TICK_DIV cycles unless a hit halts
// HALT    | stopped on hit; step executes the halting instruction, back to RUN
module exec_sequencer
    import core_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 500_000,
    parameter int CNT_W     = 16
) (
    input logic             clk,
    input logic             rst,
    exec_sequencer_if.slave bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    seq_state_t       state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             skip_q, skip_d;
    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] retired_q;
    logic             step_pulse;
    logic             tick;
    logic             hit;

    step_debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_step_debouncer (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.step_key),
        .pulse (step_pulse)
    );

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign hit  = (bus.bp_en && (bus.pc == bus.bp_addr)) || (bus.inst == EBREAK_INST);

    // Held at zero outside RUN so the first instruction lands TICK_DIV cycles after entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if ((state_q == ST_RUN) && !tick) begin
            presc_q <= presc_q + PW'(1);
        end else begin
            presc_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cpu_en_q <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        skip_d   = skip_q;
        unique case (state_q)
            ST_IDLE: begin
                skip_d = 1'b0;
                if (bus.run_sw) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.run_sw) begin
                    state_d = ST_IDLE;
                    skip_d  = 1'b0;
                end else if (tick) begin
                    if (hit && !skip_q) begin
                        state_d = ST_HALT;
                    end else begin
                        cpu_en_d = 1'b1;
                        skip_d   = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                if (!bus.run_sw) begin
                    state_d = ST_IDLE;
                end else if (step_pulse) begin
                    cpu_en_d = 1'b1;
                    skip_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                skip_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (cpu_en_q && (retired_q != {CNT_W{1'b1}})) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.cpu_en  = cpu_en_q;
    assign bus.state   = state_q;
    assign bus.halted  = (state_q == ST_HALT);
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed plus randomized bench for exec_sequencer against a cycle-level reference model.
module tb_exec_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DB       = 3;
    localparam int CNT_W    = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exec_sequencer_if #(.CNT_W(CNT_W)) bus();

    exec_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int en_count = 0;

    // Reference model: mode 0 idle, 1 run, 2 halt (matches the state output code).
    int m_mode, m_phase, m_ret, m_run;
    bit m_en, m_skip, m_k1, m_k2, m_level, m_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_ret = 0; m_run = 0;
        m_en = 0; m_skip = 0; m_k1 = 1; m_k2 = 1; m_level = 1; m_pulse = 0;
    endtask

    task automatic model_edge();
        int  n_mode, n_phase, n_run;
        bit  n_en, n_skip, n_level, n_pulse, tick, hit;
        n_mode = m_mode; n_en = 0; n_skip = m_skip;
        n_level = m_level; n_pulse = 0; n_run = 0;
        // press filter: a run of DB synchronized samples differing from the level flips it
        if (m_k2 != m_level) begin
            n_run = m_run + 1;
            if (n_run == DB) begin
                n_level = m_k2;
                n_run   = 0;
                n_pulse = !m_k2;
            end
        end
        tick = (m_mode == 1) && (m_phase == TICK_DIV - 1);
        hit  = (bus.bp_en && bus.pc == bus.bp_addr) || (bus.inst == EBRK);
        if (m_mode == 0) begin
            n_skip = 0;
            if (bus.run_sw) n_mode = 1;
            else if (m_pulse) n_en = 1;
        end else if (m_mode == 1) begin
            if (!bus.run_sw) begin
                n_mode = 0; n_skip = 0;
            end else if (tick) begin
                if (hit && !m_skip) n_mode = 2;
                else begin n_en = 1; n_skip = 0; end
            end
        end else begin
            if (!bus.run_sw) n_mode = 0;
            else if (m_pulse) begin n_en = 1; n_skip = 1; n_mode = 1; end
        end
        n_phase = (m_mode == 1 && !tick) ? m_phase + 1 : 0;
        if (m_en && m_ret != (1 << CNT_W) - 1) m_ret = m_ret + 1;
        m_mode = n_mode; m_en = n_en; m_skip = n_skip; m_phase = n_phase;
        m_level = n_level; m_run = n_run; m_pulse = n_pulse;
        m_k2 = m_k1; m_k1 = bus.step_key;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cpu_en",  32'(bus.cpu_en),  32'(m_en));
        check("state",   32'(bus.state),   32'(m_mode));
        check("halted",  32'(bus.halted),  32'(m_mode == 2));
        check("retired", 32'(bus.retired), 32'(m_ret));
        if (bus.cpu_en === 1'b1) en_count++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.run_sw = 1'b0;
        bus.step_key = 1'b1;
        #1;
        check("rst_state",   32'(bus.state),   32'd0);
        check("rst_cpu_en",  32'(bus.cpu_en),  32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("rst_halted",  32'(bus.halted),  32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int hold;

    initial begin
        bus.run_sw = 1'b0; bus.step_key = 1'b1; bus.bp_en = 1'b0;
        bus.bp_addr = 8'h08; bus.pc = 8'h00; bus.inst = NOP;
        do_reset();

        // free-run: first pulse 4 cycles after entry, then every 4
        bus.run_sw = 1'b1;
        en_count = 0;
        repeat (21) step_cycle();
        check("run_pulses", 32'(en_count), 32'd5);
        step_cycle();
        check("run_retired", 32'(bus.retired), 32'd5);
        repeat (3) step_cycle();
        check("pre_rst_en", 32'(bus.cpu_en), 32'd1);
        do_reset();

        // bounce then a genuine press in IDLE, then release and a short glitch
        en_count = 0;
        bus.step_key = 1'b0; step_cycle();
        bus.step_key = 1'b1; step_cycle();
        bus.step_key = 1'b0; step_cycle();
        bus.step_key = 1'b1; step_cycle();
        bus.step_key = 1'b0; repeat (10) step_cycle();
        bus.step_key = 1'b1; repeat (3) step_cycle();
        check("bounce_pulses", 32'(en_count), 32'd1);
        en_count = 0;
        repeat (5) step_cycle();
        bus.step_key = 1'b0; repeat (2) step_cycle();
        bus.step_key = 1'b1; repeat (8) step_cycle();
        check("glitch_pulses", 32'(en_count), 32'd0);
        check("glitch_state", 32'(bus.state), 32'd0);

        // PC breakpoint, step-over, re-halt on the following tick
        bus.bp_en = 1'b1; bus.bp_addr = 8'h08; bus.pc = 8'h08; bus.run_sw = 1'b1;
        en_count = 0;
        repeat (6) step_cycle();
        check("bp_state", 32'(bus.state), 32'd2);
        check("bp_halted", 32'(bus.halted), 32'd1);
        check("bp_no_en", 32'(en_count), 32'd0);
        bus.step_key = 1'b0;
        repeat (8) step_cycle();
        check("bp_step_en", 32'(en_count), 32'd1);
        check("bp_step_state", 32'(bus.state), 32'd1);
        bus.step_key = 1'b1;
        en_count = 0;
        repeat (4) step_cycle();
        check("bp_skip_tick", 32'(en_count), 32'd1);
        check("bp_skip_state", 32'(bus.state), 32'd1);
        repeat (4) step_cycle();
        check("bp_rehalt", 32'(bus.state), 32'd2);
        check("bp_rehalt_en", 32'(en_count), 32'd1);
        bus.run_sw = 1'b0;
        repeat (2) step_cycle();
        check("bp_to_idle", 32'(bus.state), 32'd0);

        // EBREAK halts without breakpoint compare
        bus.bp_en = 1'b0; bus.pc = 8'h00; bus.inst = EBRK; bus.run_sw = 1'b1;
        en_count = 0;
        repeat (6) step_cycle();
        check("ebreak_state", 32'(bus.state), 32'd2);
        check("ebreak_halted", 32'(bus.halted), 32'd1);
        check("ebreak_no_en", 32'(en_count), 32'd0);
        bus.run_sw = 1'b0; bus.inst = NOP;
        repeat (2) step_cycle();

        // run_sw drops on the tick cycle
        bus.run_sw = 1'b1;
        en_count = 0;
        repeat (4) step_cycle();
        bus.run_sw = 1'b0;
        repeat (3) step_cycle();
        check("race_no_en", 32'(en_count), 32'd0);
        check("race_idle", 32'(bus.state), 32'd0);

        // step press while running is ignored; keep running to saturate
        bus.run_sw = 1'b1; bus.step_key = 1'b0;
        en_count = 0;
        repeat (12) step_cycle();
        check("run_step_ignored", 32'(en_count), 32'd2);
        check("run_step_state", 32'(bus.state), 32'd1);
        bus.step_key = 1'b1;
        repeat (80) step_cycle();
        check("saturate", 32'(bus.retired), 32'hF);

        // randomized mix against the model
        do_reset();
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) bus.run_sw = ~bus.run_sw;
            if (hold == 0) begin
                bus.step_key = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 6);
            end
            hold--;
            bus.pc    = 8'($urandom_range(6, 9));
            bus.bp_en = ($urandom_range(0, 3) != 0);
            bus.inst  = ($urandom_range(0, 7) == 0) ? EBRK : NOP;
            step_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
